// File: rtl/maszyna_w_pkg.sv
// Shared definitions for the Machine W core: control signal bit map,
// conflict groups, override register selectors, ALU op bundle and FSM states.
package maszyna_w_pkg;

    localparam int WYAK  = 0;
    localparam int WWEAK = 1;
    localparam int ODE   = 2;
    localparam int DOD   = 3;
    localparam int WYAD  = 4;
    localparam int WEI   = 5;
    localparam int IL    = 6;
    localparam int WYL   = 7;
    localparam int WEL   = 8;
    localparam int WEA   = 9;
    localparam int WYS   = 10;
    localparam int WES   = 11;
    localparam int CZYT  = 12;
    localparam int PISZ  = 13;
    localparam int WEJA  = 14;
    localparam int PRZEP = 15;
    localparam int MNO   = 16;
    localparam int DZIEL = 17;
    localparam int SHR   = 18;
    localparam int NEG   = 19;
    localparam int LUB   = 20;
    localparam int I_OP  = 21;
    localparam int WYWS  = 22;
    localparam int WEWS  = 23;
    localparam int IWS   = 24;
    localparam int DWS   = 25;
    localparam int WEX   = 26;
    localparam int WYX   = 27;

    // Signals that compete for the same destination register.
    localparam logic [31:0] GRP_S  = (32'd1 << CZYT) | (32'd1 << WES);
    localparam logic [31:0] GRP_L  = (32'd1 << WEL) | (32'd1 << IL);
    localparam logic [31:0] GRP_WS = (32'd1 << WEWS) | (32'd1 << IWS) | (32'd1 << DWS);
    localparam logic [31:0] GRP_AK = (32'd1 << PRZEP) | (32'd1 << DOD) | (32'd1 << ODE)
                                   | (32'd1 << MNO) | (32'd1 << DZIEL) | (32'd1 << SHR)
                                   | (32'd1 << NEG) | (32'd1 << LUB) | (32'd1 << I_OP);

    localparam logic [2:0] SEL_L  = 3'd1;
    localparam logic [2:0] SEL_I  = 3'd2;
    localparam logic [2:0] SEL_AK = 3'd3;
    localparam logic [2:0] SEL_A  = 3'd4;
    localparam logic [2:0] SEL_S  = 3'd5;
    localparam logic [2:0] SEL_X  = 3'd6;
    localparam logic [2:0] SEL_WS = 3'd7;

    typedef struct packed {
        logic przep;
        logic dod;
        logic ode;
        logic mno;
        logic dziel;
        logic shr;
        logic neg;
        logic lub;
        logic i_op;
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } state_e;

endpackage

// File: rtl/maszyna_w_alu.sv
// Combinational accumulator ALU: combines Ak with the magAk bus under a one-hot op.
module maszyna_w_alu
    import maszyna_w_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] ak_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    input  alu_op_t               op_i,
    output logic [WORD_WIDTH-1:0] result_o,
    output logic                  div_by_zero_o
);

    // No op selected loads zero; unary ops (przep, shr, neg) act on the bus operand.
    always_comb begin
        result_o      = '0;
        div_by_zero_o = 1'b0;
        if (op_i.przep)      result_o = b_i;
        else if (op_i.dod)   result_o = ak_i + b_i;
        else if (op_i.ode)   result_o = ak_i - b_i;
        else if (op_i.mno)   result_o = ak_i * b_i;
        else if (op_i.dziel) begin
            if (b_i == '0) begin
                result_o      = ak_i;
                div_by_zero_o = 1'b1;
            end else begin
                result_o = ak_i / b_i;
            end
        end
        else if (op_i.shr)   result_o = b_i >> 1;
        else if (op_i.neg)   result_o = -b_i;
        else if (op_i.lub)   result_o = ak_i | b_i;
        else if (op_i.i_op)  result_o = ak_i & b_i;
    end

endmodule

// File: rtl/maszyna_w_core3.sv
// Machine W datapath: one microstep per step_valid/step_ready handshake, with X, WS,
// extended ALU and a synchronous RAM whose read data lands in S one cycle later.
module maszyna_w_core3
    import maszyna_w_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int KOD_WIDTH     = WORD_WIDTH - ADDRESS_WIDTH,
    parameter int SIG_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step_valid,
    output logic                     step_ready,
    input  logic [SIG_WIDTH-1:0]     signals,
    output logic                     step_done,
    output logic                     step_rejected,
    output logic [SIG_WIDTH-1:0]     signal_errors,
    output logic                     div_zero,
    input  logic                     override_write,
    input  logic [ADDRESS_WIDTH:0]   override_address,
    input  logic [WORD_WIDTH-1:0]    override_word,
    output logic [ADDRESS_WIDTH-1:0] L,
    output logic [ADDRESS_WIDTH-1:0] A,
    output logic [ADDRESS_WIDTH-1:0] WS,
    output logic [WORD_WIDTH-1:0]    I,
    output logic [WORD_WIDTH-1:0]    Ak,
    output logic [WORD_WIDTH-1:0]    S,
    output logic [WORD_WIDTH-1:0]    X,
    output logic [ADDRESS_WIDTH-1:0] magA,
    output logic [WORD_WIDTH-1:0]    magS,
    output logic                     ZF,
    output logic                     ZAK,
    output logic [KOD_WIDTH-1:0]     KOD,
    output logic [ADDRESS_WIDTH-1:0] ADRES,
    output logic                     dbg_state
);

    localparam logic [SIG_WIDTH-1:0] M_S  = SIG_WIDTH'(GRP_S);
    localparam logic [SIG_WIDTH-1:0] M_L  = SIG_WIDTH'(GRP_L);
    localparam logic [SIG_WIDTH-1:0] M_WS = SIG_WIDTH'(GRP_WS);
    localparam logic [SIG_WIDTH-1:0] M_AK = SIG_WIDTH'(GRP_AK);

    function automatic logic [SIG_WIDTH-1:0] grp_err(input logic [SIG_WIDTH-1:0] sig,
                                                     input logic [SIG_WIDTH-1:0] m);
        return ($countones(sig & m) >= 2) ? (sig & m) : '0;
    endfunction

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] l_q, l_d, a_q, a_d, ws_q, ws_d;
    logic [WORD_WIDTH-1:0]    i_q, i_d, ak_q, ak_d, s_q, s_d, x_q, x_d;
    logic                     div_zero_q, div_zero_d;
    logic                     step_done_q, step_done_d, step_rejected_q, step_rejected_d;
    logic [WORD_WIDTH-1:0]    rdata_q;
    logic [WORD_WIDTH-1:0]    mem [2**ADDRESS_WIDTH];
    logic [WORD_WIDTH-1:0]    mag_ak, alu_result;
    logic                     alu_dz, accept, step_ok, ovr_ok, ovr_reg_ok, ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_waddr;
    logic [WORD_WIDTH-1:0]    ram_wdata;
    logic                     unused_sig_bits;
    alu_op_t                  alu_op;

    assign unused_sig_bits = ^signals[SIG_WIDTH-1:28];

    // Handshake: a microstep is taken on a rising edge where step_valid && step_ready;
    // step_ready drops while a debug override is requested and during the RAM read cycle.
    assign accept  = step_valid && step_ready;
    assign step_ok = accept && (signal_errors == '0);
    assign ovr_ok  = (state_q == ST_IDLE) && override_write;
    assign ovr_reg_ok = ovr_ok && override_address[ADDRESS_WIDTH]
                        && (override_address[ADDRESS_WIDTH-1:3] == '0);

    assign signal_errors = grp_err(signals, M_S) | grp_err(signals, M_L)
                         | grp_err(signals, M_WS) | grp_err(signals, M_AK);

    assign magA = ({ADDRESS_WIDTH{signals[WYL]}}  & l_q)
                | ({ADDRESS_WIDTH{signals[WYAD]}} & i_q[WORD_WIDTH-1:KOD_WIDTH])
                | ({ADDRESS_WIDTH{signals[WYWS]}} & ws_q);
    assign magS = ({WORD_WIDTH{signals[WYS]}}  & s_q)
                | ({WORD_WIDTH{signals[WYAK]}} & ak_q)
                | ({WORD_WIDTH{signals[WYX]}}  & x_q);
    assign mag_ak = {WORD_WIDTH{signals[WEJA]}} & magS;

    assign alu_op = '{przep: signals[PRZEP], dod: signals[DOD], ode: signals[ODE],
                      mno: signals[MNO], dziel: signals[DZIEL], shr: signals[SHR],
                      neg: signals[NEG], lub: signals[LUB], i_op: signals[I_OP]};

    maszyna_w_alu #(.WORD_WIDTH(WORD_WIDTH)) u_alu (
        .ak_i          (ak_q),
        .b_i           (mag_ak),
        .op_i          (alu_op),
        .result_o      (alu_result),
        .div_by_zero_o (alu_dz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (step_ok && signals[CZYT]) state_d = ST_RD;
            ST_RD:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        step_ready = (state_q == ST_IDLE) && !override_write;
    end

    // Every update below reads only pre-edge register values.
    always_comb begin
        l_d = l_q;  a_d = a_q;  ws_d = ws_q;
        i_d = i_q;  ak_d = ak_q; s_d = s_q; x_d = x_q;
        div_zero_d      = div_zero_q;
        step_done_d     = (state_q == ST_RD) || (step_ok && !signals[CZYT]);
        step_rejected_d = accept && (signal_errors != '0);
        if (ovr_reg_ok) begin
            case (override_address[2:0])
                SEL_L:   l_d  = override_word[ADDRESS_WIDTH-1:0];
                SEL_I:   i_d  = override_word;
                SEL_AK:  ak_d = override_word;
                SEL_A:   a_d  = override_word[ADDRESS_WIDTH-1:0];
                SEL_S:   s_d  = override_word;
                SEL_X:   x_d  = override_word;
                SEL_WS:  ws_d = override_word[ADDRESS_WIDTH-1:0];
                default: ;
            endcase
        end else if (step_ok) begin
            if (signals[WEL])      l_d = magA;
            else if (signals[IL])  l_d = l_q + 1'b1;
            if (signals[WEWS])     ws_d = magA;
            else if (signals[IWS]) ws_d = ws_q + 1'b1;
            else if (signals[DWS]) ws_d = ws_q - 1'b1;
            if (signals[WEX])      x_d = magS;
            if (signals[WEI])      i_d = magS;
            if (signals[WEA])      a_d = magA;
            if (signals[WES])      s_d = magS;
            if (signals[WWEAK]) begin
                ak_d = alu_result;
                if (alu_dz) div_zero_d = 1'b1;
            end
        end
        if (state_q == ST_RD) s_d = rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_q <= '0; a_q <= '0; ws_q <= '0;
            i_q <= '0; ak_q <= '0; s_q <= '0; x_q <= '0;
            div_zero_q      <= 1'b0;
            step_done_q     <= 1'b0;
            step_rejected_q <= 1'b0;
        end else begin
            l_q <= l_d; a_q <= a_d; ws_q <= ws_d;
            i_q <= i_d; ak_q <= ak_d; s_q <= s_d; x_q <= x_d;
            div_zero_q      <= div_zero_d;
            step_done_q     <= step_done_d;
            step_rejected_q <= step_rejected_d;
        end
    end

    assign ram_we    = (step_ok && signals[PISZ]) || (ovr_ok && !override_address[ADDRESS_WIDTH]);
    assign ram_waddr = ovr_ok ? override_address[ADDRESS_WIDTH-1:0] : a_q;
    assign ram_wdata = ovr_ok ? override_word : s_q;

    // Non-blocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (step_ok && signals[CZYT]) rdata_q <= mem[a_q];
    end

    assign L  = l_q;   assign A  = a_q;  assign WS = ws_q;
    assign I  = i_q;   assign Ak = ak_q; assign S  = s_q;  assign X = x_q;
    assign ZF  = ak_q[WORD_WIDTH-1];
    assign ZAK = (ak_q == '0);
    assign KOD   = i_q[KOD_WIDTH-1:0];
    assign ADRES = i_q[WORD_WIDTH-1:KOD_WIDTH];
    assign step_done     = step_done_q;
    assign step_rejected = step_rejected_q;
    assign div_zero      = div_zero_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_maszyna_w_core3.sv
// Directed bench for maszyna_w_core3: override setup, microsteps, RAM read/write,
// ALU ops, signal conflicts and reset during the read cycle.
module tb_maszyna_w_core3;
    import maszyna_w_pkg::*;

    localparam int WW = 32, AW = 16, KW = 16, SW = 32;

    logic          clk = 1'b0;
    logic          reset, step_valid, step_ready, step_done, step_rejected, div_zero;
    logic [SW-1:0] signals, signal_errors;
    logic          override_write;
    logic [AW:0]   override_address;
    logic [WW-1:0] override_word;
    logic [AW-1:0] L, A, WS, magA, ADRES;
    logic [WW-1:0] I, Ak, S, X, magS;
    logic          ZF, ZAK, dbg_state;
    logic [KW-1:0] KOD;

    int total = 0;
    int bad   = 0;

    localparam logic [SW-1:0] ADD_OP = (32'd1 << WYS) | (32'd1 << WEJA) | (32'd1 << WWEAK);

    maszyna_w_core3 dut (
        .clk(clk), .reset(reset), .step_valid(step_valid), .step_ready(step_ready),
        .signals(signals), .step_done(step_done), .step_rejected(step_rejected),
        .signal_errors(signal_errors), .div_zero(div_zero), .override_write(override_write),
        .override_address(override_address), .override_word(override_word),
        .L(L), .A(A), .WS(WS), .I(I), .Ak(Ak), .S(S), .X(X), .magA(magA), .magS(magS),
        .ZF(ZF), .ZAK(ZAK), .KOD(KOD), .ADRES(ADRES), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] b(input int idx);
        return SW'(1) << idx;
    endfunction

    function automatic logic [AW:0] rsel(input logic [2:0] code);
        return {1'b1, 13'd0, code};
    endfunction

    task automatic ovr(input logic [AW:0] addr, input logic [WW-1:0] w);
        @(negedge clk);
        override_write = 1'b1; override_address = addr; override_word = w;
        @(negedge clk);
        override_write = 1'b0;
    endtask

    task automatic step(input logic [SW-1:0] sig);
        @(negedge clk);
        step_valid = 1'b1; signals = sig;
        @(negedge clk);
        step_valid = 1'b0; signals = '0;
    endtask

    task automatic step_rd(input logic [SW-1:0] sig);
        step(sig);
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (step_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", step_ready); end
        total++; if ({L, A, WS} !== '0) begin bad++; $display("FAIL reset_addr_regs got %h want 0", {L, A, WS}); end
        total++; if ({I, Ak, S, X} !== '0) begin bad++; $display("FAIL reset_word_regs got %h want 0", {I, Ak, S, X}); end
        total++; if ({step_done, step_rejected, div_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {step_done, step_rejected, div_zero}); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got %b want %b", dbg_state, ST_IDLE); end
    endtask

    task automatic test_read();
        ovr(rsel(SEL_A), 32'd5);
        ovr({1'b0, 16'd5}, 32'h1234);
        total++; if (A !== 16'd5) begin bad++; $display("FAIL ovr_a got %h want 5", A); end
        step(b(CZYT));
        total++; if (step_ready !== 1'b0) begin bad++; $display("FAIL rd_ready got %b want 0", step_ready); end
        total++; if (dbg_state !== ST_RD) begin bad++; $display("FAIL rd_state got %b want %b", dbg_state, ST_RD); end
        total++; if (step_done !== 1'b0) begin bad++; $display("FAIL rd_early_done got %b want 0", step_done); end
        @(negedge clk);
        total++; if (S !== 32'h1234) begin bad++; $display("FAIL rd_s got %h want 1234", S); end
        total++; if ({step_done, step_ready} !== 2'b11) begin bad++; $display("FAIL rd_done got %b want 11", {step_done, step_ready}); end
        @(negedge clk);
        total++; if (step_done !== 1'b0) begin bad++; $display("FAIL rd_single_pulse got %b want 0", step_done); end
    endtask

    task automatic test_add_sub();
        ovr(rsel(SEL_AK), 32'd7);
        ovr(rsel(SEL_S), 32'd3);
        step(ADD_OP | b(DOD));
        total++; if (Ak !== 32'd10) begin bad++; $display("FAIL dod got %h want a", Ak); end
        total++; if (step_done !== 1'b1) begin bad++; $display("FAIL dod_done got %b want 1", step_done); end
        ovr(rsel(SEL_S), 32'd20);
        step(ADD_OP | b(ODE));
        total++; if (Ak !== 32'hFFFF_FFF6) begin bad++; $display("FAIL ode got %h want fffffff6", Ak); end
        total++; if ({ZF, ZAK} !== 2'b10) begin bad++; $display("FAIL ode_flags got %b want 10", {ZF, ZAK}); end
    endtask

    task automatic test_div();
        ovr(rsel(SEL_AK), 32'h10);
        ovr(rsel(SEL_S), 32'd0);
        step(ADD_OP | b(DZIEL));
        total++; if (Ak !== 32'h10) begin bad++; $display("FAIL div0_ak got %h want 10", Ak); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL div0_flag got %b want 1", div_zero); end
        ovr(rsel(SEL_S), 32'd4);
        step(ADD_OP | b(DZIEL));
        total++; if (Ak !== 32'd4) begin bad++; $display("FAIL div_ak got %h want 4", Ak); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL div0_sticky got %b want 1", div_zero); end
    endtask

    task automatic test_alu_ops();
        logic [SW-1:0] sigs [8];
        logic [WW-1:0] exps [8];
        sigs[0] = ADD_OP | b(MNO);            exps[0] = 32'd12;
        sigs[1] = ADD_OP | b(NEG);            exps[1] = 32'hFFFF_FFFD;
        sigs[2] = ADD_OP | b(LUB);            exps[2] = 32'hFFFF_FFFF;
        sigs[3] = b(WYS) | b(WWEAK) | b(DOD); exps[3] = 32'hFFFF_FFFF;
        sigs[4] = ADD_OP | b(I_OP);           exps[4] = 32'd3;
        sigs[5] = ADD_OP | b(SHR);            exps[5] = 32'd1;
        sigs[6] = b(WWEAK);                   exps[6] = 32'd0;
        sigs[7] = ADD_OP | b(PRZEP);          exps[7] = 32'd3;
        ovr(rsel(SEL_S), 32'd3);
        for (int k = 0; k < 8; k++) begin
            step(sigs[k]);
            total++; if (Ak !== exps[k]) begin bad++; $display("FAIL alu_op%0d got %h want %h", k, Ak, exps[k]); end
            if (k == 6) begin
                total++; if (ZAK !== 1'b1) begin bad++; $display("FAIL alu_zak got %b want 1", ZAK); end
            end
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        step_valid = 1'b1;
        signals = b(CZYT) | b(WES) | b(PISZ) | b(WEA) | b(WYL);
        #1;
        total++; if (signal_errors !== (b(CZYT) | b(WES))) begin bad++; $display("FAIL err_s got %h want %h", signal_errors, b(CZYT) | b(WES)); end
        @(negedge clk);
        step_valid = 1'b0; signals = '0;
        total++; if ({step_rejected, step_done} !== 2'b10) begin bad++; $display("FAIL rej_pulse got %b want 10", {step_rejected, step_done}); end
        total++; if ({S, A, step_ready} !== {32'd3, 16'd5, 1'b1}) begin bad++; $display("FAIL rej_regs got S=%h A=%h rdy=%b want 3 5 1", S, A, step_ready); end
        @(negedge clk);
        total++; if (step_rejected !== 1'b0) begin bad++; $display("FAIL rej_single got %b want 0", step_rejected); end
        step_rd(b(CZYT));
        total++; if (S !== 32'h1234) begin bad++; $display("FAIL rej_ram got %h want 1234", S); end
        signals = b(WEL) | b(IL) | b(DOD) | b(ODE) | b(MNO) | b(WWEAK) | b(WEWS) | b(DWS);
        #1;
        total++; if (signal_errors !== (b(WEL) | b(IL) | b(DOD) | b(ODE) | b(MNO) | b(WEWS) | b(DWS))) begin bad++; $display("FAIL err_multi got %h", signal_errors); end
        signals = b(WEL) | b(DOD) | b(WEWS) | b(CZYT);
        #1;
        total++; if (signal_errors !== '0) begin bad++; $display("FAIL err_none got %h want 0", signal_errors); end
        signals = '0;
    endtask

    task automatic test_ws_ram();
        step(b(DWS));
        total++; if (WS !== 16'hFFFF) begin bad++; $display("FAIL dws_wrap got %h want ffff", WS); end
        step(b(WYWS) | b(WEA));
        total++; if (A !== 16'hFFFF) begin bad++; $display("FAIL wyws_wea got %h want ffff", A); end
        ovr(rsel(SEL_S), 32'hAA);
        step(b(PISZ));
        ovr(rsel(SEL_S), 32'd0);
        step_rd(b(CZYT));
        total++; if (S !== 32'hAA) begin bad++; $display("FAIL pisz_ffff got %h want aa", S); end
        ovr(rsel(SEL_S), 32'h55);
        step_rd(b(CZYT) | b(PISZ));
        total++; if (S !== 32'hAA) begin bad++; $display("FAIL read_first got %h want aa", S); end
        ovr(rsel(SEL_S), 32'd0);
        step_rd(b(CZYT));
        total++; if (S !== 32'h55) begin bad++; $display("FAIL read_first_wr got %h want 55", S); end
        step(b(IWS));
        total++; if (WS !== 16'h0000) begin bad++; $display("FAIL iws_wrap got %h want 0", WS); end
        ovr(rsel(SEL_L), 32'hFFFF);
        step(b(IL));
        total++; if (L !== 16'h0000) begin bad++; $display("FAIL il_wrap got %h want 0", L); end
    endtask

    task automatic test_xi_override();
        ovr(rsel(SEL_S), 32'hABCD_0007);
        step(b(WYS) | b(WEX) | b(WEI));
        total++; if ({X, I} !== {32'hABCD_0007, 32'hABCD_0007}) begin bad++; $display("FAIL wex_wei got X=%h I=%h want abcd0007", X, I); end
        total++; if ({ADRES, KOD} !== 32'hABCD_0007) begin bad++; $display("FAIL kod_adres got %h %h want abcd 0007", ADRES, KOD); end
        step(b(WYAD) | b(WEL));
        total++; if (L !== 16'hABCD) begin bad++; $display("FAIL wyad_wel got %h want abcd", L); end
        ovr({1'b0, 16'd0}, 32'h11);
        ovr(rsel(3'd0), 32'h99);
        ovr({1'b1, 16'd9}, 32'h99);
        ovr(rsel(SEL_A), 32'd0);
        step_rd(b(CZYT));
        total++; if (S !== 32'h11) begin bad++; $display("FAIL ovr_ignored_ram got %h want 11", S); end
        total++; if ({L, X} !== {16'hABCD, 32'hABCD_0007}) begin bad++; $display("FAIL ovr_ignored_regs got L=%h X=%h", L, X); end
        @(negedge clk);
        override_write = 1'b1; override_address = rsel(SEL_X); override_word = 32'h77;
        step_valid = 1'b1; signals = b(WYS) | b(WEX);
        #1;
        total++; if (step_ready !== 1'b0) begin bad++; $display("FAIL ovr_blocks_ready got %b want 0", step_ready); end
        @(negedge clk);
        override_write = 1'b0; step_valid = 1'b0; signals = '0;
        total++; if ({X, step_done} !== {32'h77, 1'b0}) begin bad++; $display("FAIL ovr_priority got X=%h done=%b want 77 0", X, step_done); end
    endtask

    task automatic test_reset_rd();
        step(b(CZYT));
        total++; if (dbg_state !== ST_RD) begin bad++; $display("FAIL rst_rd_pre got %b want %b", dbg_state, ST_RD); end
        reset = 1'b1;
        #1;
        total++; if ({L, A, WS, I, Ak, S, X} !== '0) begin bad++; $display("FAIL rst_rd_regs got nonzero S=%h X=%h", S, X); end
        total++; if ({dbg_state, step_ready, div_zero} !== {ST_IDLE, 1'b1, 1'b0}) begin bad++; $display("FAIL rst_rd_state got %b", {dbg_state, step_ready, div_zero}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if ({step_done, S} !== '0) begin bad++; $display("FAIL rst_rd_no_done got done=%b S=%h", step_done, S); end
        @(negedge clk);
        total++; if (step_done !== 1'b0) begin bad++; $display("FAIL rst_rd_no_done2 got %b want 0", step_done); end
    endtask

    initial begin
        reset = 1'b1; step_valid = 1'b0; signals = '0;
        override_write = 1'b0; override_address = '0; override_word = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_read();
        test_add_sub();
        test_div();
        test_alu_ops();
        test_conflict();
        test_ws_ram();
        test_xi_override();
        test_reset_rd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
